// File: rtl/ifeedback_lock_supervisor_pkg.sv
// ifeedback_lock_supervisor_pkg: state encoding, control-rail limits and counter sizing shared by the supervisor.
package ifeedback_lock_supervisor_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_RAILED  = 3'd4,
        ST_FAULT   = 3'd5
    } state_e;
    localparam logic signed [13:0] CTRL_MAX = 14'sd8191;
    localparam logic signed [13:0] CTRL_MIN = -14'sd8192;
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        m = m > d ? m : d;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/supervisor_abs_band.sv
// supervisor_abs_band: registered |error| saturate/threshold compare and control-rail detect.
module supervisor_abs_band
    import ifeedback_lock_supervisor_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic signed [13:0] err_in,
    input  logic signed [13:0] ctrl_in,
    input  logic        [12:0] thresh_in,
    output logic               in_band_q,
    output logic               railed_q
);
    logic [12:0] abs_err;
    logic        in_band_d;
    logic        railed_d;
    always_comb begin
        // -8192 has no positive 14-bit twin, so it folds onto the largest magnitude
        abs_err   = err_in == CTRL_MIN ? 13'h1FFF : err_in[13] ? 13'(-err_in) : err_in[12:0];
        in_band_d = abs_err <= thresh_in;
        railed_d  = ctrl_in == CTRL_MAX || ctrl_in == CTRL_MIN;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_band_q <= 1'b0;
            railed_q  <= 1'b0;
        end else begin
            in_band_q <= in_band_d;
            railed_q  <= railed_d;
        end
    end
endmodule

// File: rtl/ifeedback_lock_supervisor.sv
// ifeedback_lock_supervisor: sequences the I feedback loop through reset/acquire/lock
// and performs bounded automatic relocks when the control output rails.
module ifeedback_lock_supervisor
    import ifeedback_lock_supervisor_pkg::*;
#(
    parameter int LOCK_CYCLES   = 65536,
    parameter int UNLOCK_CYCLES = 1024,
    parameter int RAIL_CYCLES   = 4096,
    parameter int RESET_CYCLES  = 16,
    parameter int RELOCK_MAX    = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [13:0] errorMonitorIn,
    input  logic signed [13:0] controlSignalIn,
    input  logic        [12:0] lockThreshIn,
    output logic               intResetOut,
    output logic               intHoldOut,
    output logic               locked,
    output logic               fault,
    output logic        [2:0]  relockCount,
    output logic        [2:0]  stateOut
);
    localparam int CW = cnt_width(LOCK_CYCLES, UNLOCK_CYCLES, RAIL_CYCLES, RESET_CYCLES);
    logic          in_band;
    logic          railed;
    state_e        state_q, state_d;
    logic [CW-1:0] run_cnt_q, run_cnt_d, run_inc;
    logic [CW-1:0] rail_cnt_q, rail_cnt_d, rail_inc;
    logic [2:0]    relock_q, relock_d;
    logic          rst_out_q, rst_out_d;
    logic          hold_q, hold_d;
    logic          locked_q, locked_d;
    logic          fault_q, fault_d;
    logic          rail_hit;
    supervisor_abs_band u_band (
        .clock     (clock),
        .reset     (reset),
        .err_in    (errorMonitorIn),
        .ctrl_in   (controlSignalIn),
        .thresh_in (lockThreshIn),
        .in_band_q (in_band),
        .railed_q  (railed)
    );
    always_comb begin
        run_inc    = &run_cnt_q ? run_cnt_q : run_cnt_q + CW'(1);
        rail_inc   = &rail_cnt_q ? rail_cnt_q : rail_cnt_q + CW'(1);
        rail_hit   = railed && rail_inc >= CW'(RAIL_CYCLES);
        state_d    = state_q;
        run_cnt_d  = '0;
        rail_cnt_d = '0;
        relock_d   = relock_q;
        case (state_q)
            ST_IDLE:    state_d = enable ? ST_RESET : ST_IDLE;
            ST_RESET: begin
                if (run_inc >= CW'(RESET_CYCLES)) state_d = ST_ACQUIRE;
                else run_cnt_d = run_inc;
            end
            ST_ACQUIRE: begin
                if (rail_hit) state_d = ST_RAILED;
                else if (in_band && run_inc >= CW'(LOCK_CYCLES)) state_d = ST_LOCKED;
                else begin
                    run_cnt_d  = in_band ? run_inc : '0;
                    rail_cnt_d = railed ? rail_inc : '0;
                end
            end
            ST_LOCKED: begin
                if (rail_hit) state_d = ST_RAILED;
                else if (!in_band && run_inc >= CW'(UNLOCK_CYCLES)) state_d = ST_ACQUIRE;
                else begin
                    run_cnt_d  = in_band ? '0 : run_inc;
                    rail_cnt_d = railed ? rail_inc : '0;
                end
            end
            ST_RAILED: begin
                state_d  = relock_q == 3'(RELOCK_MAX) ? ST_FAULT : ST_RESET;
                relock_d = relock_q == 3'(RELOCK_MAX) ? relock_q : relock_q + 3'd1;
            end
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d    = ST_IDLE;
            run_cnt_d  = '0;
            rail_cnt_d = '0;
        end
        // clear on entry so the count reads zero the first cycle IDLE is visible
        if (state_d == ST_IDLE) relock_d = '0;
        rst_out_d = state_d == ST_IDLE || state_d == ST_RESET || state_d == ST_FAULT;
        hold_d    = state_d == ST_RAILED;
        locked_d  = state_d == ST_LOCKED;
        fault_d   = state_d == ST_FAULT;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            run_cnt_q  <= '0;
            rail_cnt_q <= '0;
            relock_q   <= '0;
            rst_out_q  <= 1'b1;
            hold_q     <= 1'b0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            rail_cnt_q <= rail_cnt_d;
            relock_q   <= relock_d;
            rst_out_q  <= rst_out_d;
            hold_q     <= hold_d;
            locked_q   <= locked_d;
            fault_q    <= fault_d;
        end
    end
    assign intResetOut = rst_out_q;
    assign intHoldOut  = hold_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign relockCount = relock_q;
    assign stateOut    = state_q;
endmodule

// File: tb/tb_ifeedback_lock_supervisor.sv
// tb_ifeedback_lock_supervisor: directed sequence through reset, lock, unlock, rail relocks,
// fault, abs saturation, simultaneous thresholds and async reset.
module tb_ifeedback_lock_supervisor;
    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [13:0] err;
    logic signed [13:0] ctrl;
    logic        [12:0] thresh;
    logic               rst_o, hold_o, locked_o, fault_o;
    logic        [2:0]  relock_o, state_o;
    int checks = 0;
    int failures = 0;
    ifeedback_lock_supervisor #(
        .LOCK_CYCLES(8), .UNLOCK_CYCLES(4), .RAIL_CYCLES(4), .RESET_CYCLES(3), .RELOCK_MAX(2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .errorMonitorIn  (err),
        .controlSignalIn (ctrl),
        .lockThreshIn    (thresh),
        .intResetOut     (rst_o),
        .intHoldOut      (hold_o),
        .locked          (locked_o),
        .fault           (fault_o),
        .relockCount     (relock_o),
        .stateOut        (state_o)
    );
    always #5 clock = ~clock;
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask
    task automatic chk_all(input string tag, input int st, input int r, input int h, input int l,
                           input int f, input int rc);
        chk({tag, ".state"}, int'(state_o), st);
        chk({tag, ".rst"}, int'(rst_o), r);
        chk({tag, ".hold"}, int'(hold_o), h);
        chk({tag, ".locked"}, int'(locked_o), l);
        chk({tag, ".fault"}, int'(fault_o), f);
        chk({tag, ".relock"}, int'(relock_o), rc);
    endtask
    task automatic do_rail(input logic signed [13:0] c, input int exp_relock, input bit to_fault);
        ctrl = c;
        tick(4);
        chk_all("rail_pre", 3, 0, 0, 1, 0, exp_relock - 1);
        ctrl = 14'sd0;
        tick(1);
        chk_all("railed", 4, 0, 1, 0, 0, exp_relock - 1);
        tick(1);
        if (to_fault) begin
            chk_all("fault", 5, 1, 0, 0, 1, exp_relock - 1);
        end else begin
            chk_all("relock_reset", 1, 1, 0, 0, 0, exp_relock);
            tick(2);
            chk("relock_rst3", int'(rst_o), 1);
            tick(1);
            chk_all("relock_acq", 2, 0, 0, 0, 0, exp_relock);
            tick(8);
            chk_all("relock_locked", 3, 0, 0, 1, 0, exp_relock);
        end
    endtask
    initial begin
        reset = 1'b1; enable = 1'b0; err = 14'sd0; ctrl = 14'sd0; thresh = 13'd10;
        #3;
        chk_all("reset_vals", 0, 1, 0, 0, 0, 0);
        tick(2);
        reset = 1'b0;
        enable = 1'b1;
        tick(2);
        chk("mid_reset_state", int'(state_o), 1);
        #2 reset = 1'b1;
        #1;
        chk_all("async_mid_reset", 0, 1, 0, 0, 0, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        tick(1);
        chk_all("reset_st", 1, 1, 0, 0, 0, 0);
        tick(2);
        chk("reset_st3", int'(rst_o), 1);
        tick(1);
        chk_all("acquire", 2, 0, 0, 0, 0, 0);
        tick(7);
        chk_all("acq_before_lock", 2, 0, 0, 0, 0, 0);
        tick(1);
        chk_all("locked", 3, 0, 0, 1, 0, 0);
        err = 14'sd50;
        tick(3);
        err = 14'sd0;
        tick(4);
        chk_all("short_excursion", 3, 0, 0, 1, 0, 0);
        err = 14'sd50;
        tick(4);
        chk("unlock_pre", int'(locked_o), 1);
        err = 14'sd0;
        tick(1);
        chk_all("unlocked", 2, 0, 0, 0, 0, 0);
        tick(7);
        chk("reacq_pre", int'(state_o), 2);
        tick(1);
        chk("relocked", int'(locked_o), 1);
        do_rail(14'sd8191, 1, 1'b0);
        do_rail(-14'sd8192, 2, 1'b0);
        do_rail(14'sd8191, 3, 1'b1);
        tick(3);
        chk_all("fault_sticky", 5, 1, 0, 0, 1, 2);
        enable = 1'b0;
        tick(1);
        chk_all("idle_after_fault", 0, 1, 0, 0, 0, 0);
        err = -14'sd8192; thresh = 13'd8191; enable = 1'b1;
        tick(12);
        chk_all("abs_sat_locked", 3, 0, 0, 1, 0, 0);
        thresh = 13'd8190;
        tick(4);
        chk("thresh_edge_pre", int'(state_o), 3);
        tick(1);
        chk("thresh_edge_unlock", int'(state_o), 2);
        enable = 1'b0;
        thresh = 13'd8191;
        tick(1);
        chk("disable_idle", int'(state_o), 0);
        enable = 1'b1;
        tick(7);
        chk("simul_acq", int'(state_o), 2);
        ctrl = 14'sd8191;
        tick(4);
        chk("simul_pre", int'(state_o), 2);
        tick(1);
        chk_all("simul_railed", 4, 0, 1, 0, 0, 0);
        ctrl = 14'sd0;
        tick(1);
        chk_all("simul_relock", 1, 1, 0, 0, 0, 1);
        tick(3);
        chk("simul_acq2", int'(state_o), 2);
        tick(8);
        chk_all("simul_locked", 3, 0, 0, 1, 0, 1);
        #2 reset = 1'b1;
        #1;
        chk_all("async_mid_locked", 0, 1, 0, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("post_reset_restart", int'(state_o), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
